// File: rtl/audio_fifo_1024x9_ctrl_pkg.sv
// Shared sizing for the audio FIFO controller: defaults, depth and level-width derivation.
package audio_fifo_1024x9_ctrl_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 10;
  localparam int unsigned DEF_DATA_WIDTH    = 9;
  localparam int unsigned DEF_AFULL_THRESH  = 960;
  localparam int unsigned DEF_AEMPTY_THRESH = 64;

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  // RAM words plus one in-flight read plus the 2-entry output buffer.
  function automatic int unsigned level_width(input int unsigned aw);
    return aw + 2;
  endfunction

endpackage

// File: rtl/audio_fifo_1024x9_ctrl_out_buf.sv
// 2-entry first-word-fall-through buffer fed by RAM read returns.
module audio_fifo_1024x9_ctrl_out_buf
  import audio_fifo_1024x9_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_load_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic [1:0]            o_cnt
);

  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic [1:0]            r_cnt;

  // Loads only arrive when there is room and pops only when valid, so
  // occupancy never leaves 0..2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_buf0 <= '0;
      r_buf1 <= '0;
      r_cnt  <= '0;
    end else begin
      unique case ({i_load, i_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_buf0 <= i_load_data;
          else               r_buf1 <= i_load_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= i_load_data;
          end else begin
            r_buf0 <= i_load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data  = r_buf0;
  assign o_valid = (r_cnt != 2'd0);
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/audio_fifo_1024x9_ctrl.sv
// FIFO controller for an external 1-cycle-latency simple-dual-port RAM with
// valid/ready input, FWFT output, fill level and almost flags.
module audio_fifo_1024x9_ctrl
  import audio_fifo_1024x9_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned AFULL_THRESH  = DEF_AFULL_THRESH,
  parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int unsigned         DEPTH    = fifo_depth(ADDR_WIDTH);
  localparam int unsigned         LVL_W    = level_width(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_C  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [LVL_W-1:0]    AFULL_C  = LVL_W'(AFULL_THRESH);
  localparam logic [LVL_W-1:0]    AEMPTY_C = LVL_W'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_inflight;
  logic                  r_s_ready;
  logic [LVL_W-1:0]      r_level;
  logic                  r_afull;
  logic                  r_aempty;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic                  w_m_valid;
  logic [1:0]            w_out_cnt;
  logic [1:0]            w_out_cnt_next;
  logic [2:0]            w_occ;
  logic [ADDR_WIDTH:0]   w_ram_cnt_next;
  logic [LVL_W-1:0]      w_level_next;

  // A read may be issued into a full buffer only when the head leaves this cycle,
  // so buffer occupancy plus the in-flight word never exceeds 2.
  always_comb begin
    w_push = s_valid && r_s_ready && !flush;
    w_pop  = w_m_valid && m_ready && !flush;
    w_occ  = {1'b0, w_out_cnt} + {2'b00, r_inflight};
    w_issue = !flush && (r_ram_cnt != '0) &&
              ((w_occ < 3'd2) || ((w_occ == 3'd2) && w_pop));

    w_ram_cnt_next = r_ram_cnt;
    if (flush)                 w_ram_cnt_next = '0;
    else if (w_push && !w_issue) w_ram_cnt_next = r_ram_cnt + CNT_ONE;
    else if (!w_push && w_issue) w_ram_cnt_next = r_ram_cnt - CNT_ONE;

    w_out_cnt_next = w_out_cnt;
    if (flush)                   w_out_cnt_next = '0;
    else if (r_inflight && !w_pop) w_out_cnt_next = w_out_cnt + 2'd1;
    else if (!r_inflight && w_pop) w_out_cnt_next = w_out_cnt - 2'd1;

    w_level_next = LVL_W'(w_ram_cnt_next) + LVL_W'(w_issue) + LVL_W'(w_out_cnt_next);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_inflight <= 1'b0;
      r_s_ready  <= 1'b0;
      r_level    <= '0;
      r_afull    <= 1'b0;
      r_aempty   <= 1'b1;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_issue) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      r_ram_cnt  <= w_ram_cnt_next;
      r_inflight <= w_issue;
      r_s_ready  <= (w_ram_cnt_next < DEPTH_C) && !flush;
      r_level    <= w_level_next;
      r_afull    <= (w_level_next >= AFULL_C);
      r_aempty   <= (w_level_next <= AEMPTY_C);
    end
  end

  audio_fifo_1024x9_ctrl_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .rst         (rst),
    .i_flush     (flush),
    .i_load      (r_inflight),
    .i_load_data (ram_rd_data),
    .i_pop       (w_pop),
    .o_data      (m_data),
    .o_valid     (w_m_valid),
    .o_cnt       (w_out_cnt)
  );

  assign s_ready      = r_s_ready;
  assign m_valid      = w_m_valid;
  assign level        = r_level;
  assign almost_full  = r_afull;
  assign almost_empty = r_aempty;
  assign ram_wr_en    = w_push;
  assign ram_wr_addr  = r_wr_ptr;
  assign ram_wr_data  = w_push ? s_data : '0;
  assign ram_rd_addr  = r_rd_ptr;

endmodule

// File: tb/tb_audio_fifo_1024x9_ctrl.sv
// Bench for audio_fifo_1024x9_ctrl with a behavioural 1024x9 RAM and a queue reference model.
module tb_audio_fifo_1024x9_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [8:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [8:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [11:0] level;
  logic        almost_full;
  logic        almost_empty;
  logic        ram_wr_en;
  logic [9:0]  ram_wr_addr;
  logic [8:0]  ram_wr_data;
  logic [9:0]  ram_rd_addr;
  logic [8:0]  ram_rd_data;

  logic [8:0]  ram_mem [1024];
  logic [8:0]  q [$];
  int          n_checks;
  int          n_fail;

  audio_fifo_1024x9_ctrl #(
    .ADDR_WIDTH    (10),
    .DATA_WIDTH    (9),
    .AFULL_THRESH  (960),
    .AEMPTY_THRESH (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data)
  );

  // Simple-dual-port RAM, unregistered output stage: data one cycle after the address.
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram_mem[ram_rd_addr];
  end

  always #5 clk = ~clk;

  // One clock of stimulus (already driven by the caller) checked against the queue model.
  task automatic scoreboard_cycle(output bit o_push, output bit o_pop, output logic [8:0] o_pdata);
    bit exp_push, exp_pop, was_flush;
    @(negedge clk);
    was_flush = flush;
    exp_push  = s_valid && s_ready && !flush;
    exp_pop   = m_valid && m_ready && !flush;
    o_push    = exp_push;
    o_pop     = exp_pop;
    o_pdata   = m_data;
    n_checks++;
    if (ram_wr_en !== exp_push || (exp_push && ram_wr_data !== s_data)) begin
      n_fail++;
      $display("FAIL wr_ctrl: wr_en=%0b wr_data=%h required wr_en=%0b wr_data=%h",
               ram_wr_en, ram_wr_data, exp_push, s_data);
    end
    n_checks++;
    if (m_valid && q.size() == 0) begin
      n_fail++;
      $display("FAIL m_valid_empty: m_valid=1 with m_data=%h required m_valid=0", m_data);
    end else if (exp_pop && m_data !== q[0]) begin
      n_fail++;
      $display("FAIL m_data: got %h required %h", m_data, q[0]);
    end
    if (flush) q.delete();
    else begin
      if (exp_pop && q.size() > 0) void'(q.pop_front());
      if (exp_push) q.push_back(s_data);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (int'(level) != q.size()) begin
      n_fail++;
      $display("FAIL level: got %0d required %0d", level, q.size());
    end
    n_checks++;
    if (almost_full !== (q.size() >= 960) || almost_empty !== (q.size() <= 64)) begin
      n_fail++;
      $display("FAIL flags: afull=%0b aempty=%0b required afull=%0b aempty=%0b (level %0d)",
               almost_full, almost_empty, q.size() >= 960, q.size() <= 64, q.size());
    end
    if (!was_flush) begin
      n_checks++;
      if ((q.size() < 1024 && s_ready !== 1'b1) || (q.size() == 1026 && s_ready !== 1'b0)) begin
        n_fail++;
        $display("FAIL s_ready: got %0b with %0d words held", s_ready, q.size());
      end
    end
  endtask

  task automatic drain_all();
    bit p, o;
    logic [8:0] d;
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 1200 && q.size() > 0; c++) scoreboard_cycle(p, o, d);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: %0d words left required 0", q.size());
    end
    m_ready = 1'b0;
  endtask

  task automatic test_reset();
    s_valid = 1'b1;
    s_data  = 9'h155;
    m_ready = 1'b1;
    flush   = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || level !== '0 ||
        almost_full !== 1'b0 || almost_empty !== 1'b1 || ram_wr_en !== 1'b0 ||
        ram_wr_addr !== '0 || ram_wr_data !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: s_ready=%0b m_valid=%0b m_data=%h level=%0d af=%0b ae=%0b we=%0b wa=%0d wd=%h ra=%0d required all 0 except ae=1",
               s_ready, m_valid, m_data, level, almost_full, almost_empty, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    q.delete();
    @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b1 || level !== '0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: s_ready=%0b level=%0d ae=%0b required 1 0 1", s_ready, level, almost_empty);
    end
  endtask

  task automatic test_fill_drain();
    bit p, o;
    logic [8:0] d, exp_d;
    int pushed = 0;
    int popped = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 1300; c++) begin
      s_valid = 1'b1;
      s_data  = 9'h1FF - 9'(pushed);
      scoreboard_cycle(p, o, d);
      if (p) pushed++;
      if (!s_ready && pushed >= 1024) break;
    end
    repeat (3) scoreboard_cycle(p, o, d);
    n_checks++;
    if (pushed != 1026 || level !== 12'd1026 || almost_full !== 1'b1 || s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: accepted=%0d level=%0d af=%0b s_ready=%0b required 1026 1026 1 0",
               pushed, level, almost_full, s_ready);
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 1300 && q.size() > 0; c++) begin
      scoreboard_cycle(p, o, d);
      if (o) begin
        exp_d = 9'h1FF - 9'(popped);
        n_checks++;
        if (d !== exp_d) begin
          n_fail++;
          $display("FAIL drain_order: word %0d got %h required %h", popped, d, exp_d);
        end
        popped++;
      end
    end
    n_checks++;
    if (popped != 1026 || level !== '0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_empty: popped=%0d level=%0d ae=%0b required 1026 0 1", popped, level, almost_empty);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_latency();
    bit p, o;
    logic [8:0] d;
    s_valid = 1'b1;
    s_data  = 9'h0A5;
    m_ready = 1'b0;
    scoreboard_cycle(p, o, d);
    s_valid = 1'b0;
    scoreboard_cycle(p, o, d);
    n_checks++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_n1: m_valid=%0b required 0", m_valid);
    end
    scoreboard_cycle(p, o, d);
    n_checks++;
    if (m_valid !== 1'b1 || m_data !== 9'h0A5) begin
      n_fail++;
      $display("FAIL latency_n2: m_valid=%0b m_data=%h required 1 0a5", m_valid, m_data);
    end
    drain_all();
  endtask

  task automatic test_back_to_back();
    bit p, o;
    logic [8:0] d;
    int both = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      s_data = 9'($urandom);
      scoreboard_cycle(p, o, d);
      if (c >= 10 && p && o) both++;
    end
    n_checks++;
    if (both != 2990) begin
      n_fail++;
      $display("FAIL throughput: push+pop cycles=%0d required 2990", both);
    end
    drain_all();
  endtask

  task automatic test_random();
    bit p, o;
    logic [8:0] d;
    for (int c = 0; c < 20000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = 9'($urandom);
      scoreboard_cycle(p, o, d);
      n_checks++;
      if (level > 12'd1026) begin
        n_fail++;
        $display("FAIL level_range: got %0d required <= 1026", level);
      end
    end
    drain_all();
  endtask

  task automatic test_flush();
    bit p, o;
    logic [8:0] d;
    bit got = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = 9'($urandom);
      scoreboard_cycle(p, o, d);
    end
    s_valid = 1'b0;
    repeat (3) scoreboard_cycle(p, o, d);
    m_ready = 1'b1;
    scoreboard_cycle(p, o, d);
    flush   = 1'b1;
    s_valid = 1'b1;
    s_data  = 9'h055;
    scoreboard_cycle(p, o, d);
    n_checks++;
    if (m_valid !== 1'b0 || level !== '0) begin
      n_fail++;
      $display("FAIL flush_clear: m_valid=%0b level=%0d required 0 0", m_valid, level);
    end
    flush   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    scoreboard_cycle(p, o, d);
    n_checks++;
    if (s_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: s_ready=%0b required 1", s_ready);
    end
    s_valid = 1'b1;
    s_data  = 9'h123;
    scoreboard_cycle(p, o, d);
    s_valid = 1'b0;
    m_ready = 1'b1;
    for (int c = 0; c < 8 && !got; c++) begin
      scoreboard_cycle(p, o, d);
      if (o) begin
        got = 1'b1;
        n_checks++;
        if (d !== 9'h123) begin
          n_fail++;
          $display("FAIL flush_next: got %h required 123", d);
        end
      end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL flush_next_timeout: no output within 8 cycles required 123");
    end
    drain_all();
  endtask

  task automatic test_reset_wrap();
    bit p, o;
    logic [8:0] d;
    int popped = 0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 1018; c++) begin
      s_data = 9'($urandom);
      scoreboard_cycle(p, o, d);
    end
    m_ready = 1'b0;
    repeat (3) begin
      s_data = 9'($urandom);
      scoreboard_cycle(p, o, d);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (s_ready !== 1'b0 || m_valid !== 1'b0 || m_data !== '0 || level !== '0 ||
        almost_full !== 1'b0 || almost_empty !== 1'b1 || ram_wr_en !== 1'b0 ||
        ram_wr_addr !== '0 || ram_wr_data !== '0 || ram_rd_addr !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: s_ready=%0b m_valid=%0b m_data=%h level=%0d af=%0b ae=%0b we=%0b wa=%0d wd=%h ra=%0d required all 0 except ae=1",
               s_ready, m_valid, m_data, level, almost_full, almost_empty, ram_wr_en, ram_wr_addr, ram_wr_data, ram_rd_addr);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (s_ready !== 1'b1 || level !== '0) begin
      n_fail++;
      $display("FAIL reset_wrap_release: s_ready=%0b level=%0d required 1 0", s_ready, level);
    end
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int c = 0; c < 1100 && popped < 1030; c++) begin
      s_data = 9'($urandom);
      scoreboard_cycle(p, o, d);
      if (o) popped++;
    end
    n_checks++;
    if (popped != 1030) begin
      n_fail++;
      $display("FAIL wrap_stream: popped=%0d required 1030", popped);
    end
    drain_all();
  endtask

  initial begin
    clk      = 1'b0;
    rst      = 1'b0;
    flush    = 1'b0;
    s_data   = '0;
    s_valid  = 1'b0;
    m_ready  = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_fill_drain();
    test_latency();
    test_back_to_back();
    test_random();
    test_flush();
    test_reset_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
